// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I load/store path.
//  - Opcode constants for LOAD / STORE
//  - funct3 size/sign encodings
//  - LSU FSM state enum
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic for the load/store unit.
//  is_store  : 1 = store access, 0 = load access
//  funct3    : size/sign field
//  addr_lo   : byte offset within the word
//  wdata     : store data, LSB-justified
//  rdata     : bus read word
//  be        : byte enables for the access
//  wdata_rep : store data replicated into every lane of its size
//  load_data : selected lane, sign- or zero-extended
//  misalign  : halfword at odd offset or word at non-zero offset
//  illegal   : funct3 not defined for this access direction
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    misalign  = 1'b0;
    illegal   = 1'b0;

    // Stores have no unsigned forms; loads reject 011 and 11x.
    if (is_store) begin
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    end else begin
      illegal = (funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11);
    end

    // funct3[1:0] carries the size for both signed and unsigned forms.
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        be        = '0;
        wdata_rep = '0;
      end
    endcase
  end

  // Lane selection equals rdata >> (8*addr_lo) for the aligned cases.
  always_comb begin
    ld_byte   = '0;
    ld_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = '0;
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'b0, ld_byte};
      F3_HU:   load_data = {16'b0, ld_half};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit behind the RV32I ALU. One access at a time.
//  Handshakes: a transfer happens on a rising edge where valid and ready
//  are both high. req_* is the execute-side handshake (ready only in IDLE);
//  mem_req_* is the bus request, with every mem_* output held stable while
//  mem_req_valid=1 and mem_req_ready=0. Writes complete at the request
//  handshake; reads complete on mem_rsp_valid (no ready on the response).
// Ports:
//  clk, rst                     clock, synchronous active-high reset
//  req_valid/req_ready          execute-stage handshake
//  opcode, funct3, addr, wdata, rd_tag   access description
//  mem_req_valid/mem_req_ready  bus request handshake
//  mem_addr, mem_we, mem_be, mem_wdata   bus request payload
//  mem_rsp_valid, mem_rsp_rdata bus read response
//  done, wb_we, wb_data, wb_tag completion / writeback
//  err_misalign, err_bus        error flags, valid with done
//  dbg_state                    current FSM state
module rv_lsu
  import rv_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_rdata,
  output logic             done,
  output logic             wb_we,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             err_misalign,
  output logic             err_bus,
  output lsu_state_t       dbg_state
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(RSP_TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       alo_q, alo_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             wb_we_q, wb_we_d;
  logic             err_mis_q, err_mis_d;
  logic             err_bus_q, err_bus_d;

  // The align block sees the live request while IDLE (to decide acceptance)
  // and the captured access afterwards (to extract the read response).
  logic        in_idle;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_alo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misalign;
  logic        al_illegal;

  assign in_idle  = (state_q == IDLE);
  assign al_store = in_idle ? (opcode == OPC_STORE) : store_q;
  assign al_f3    = in_idle ? funct3 : f3_q;
  assign al_alo   = in_idle ? addr[1:0] : alo_q;

  rv_lsu_align u_align (
    .is_store  (al_store),
    .funct3    (al_f3),
    .addr_lo   (al_alo),
    .wdata     (wdata),
    .rdata     (mem_rsp_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_data (al_load),
    .misalign  (al_misalign),
    .illegal   (al_illegal)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    wb_data_d   = wb_data_q;
    wb_tag_d    = wb_tag_q;
    // Completion flags are only ever set on the edge entering DONE, so
    // they last exactly the one DONE cycle.
    wb_we_d     = 1'b0;
    err_mis_d   = 1'b0;
    err_bus_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d     = (opcode == OPC_STORE);
          f3_d        = funct3;
          alo_d       = addr[1:0];
          wb_tag_d    = rd_tag;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = al_be;
          mem_wdata_d = al_wdata;
          mem_we_d    = (opcode == OPC_STORE);
          // An illegal encoding has no meaningful size, so it takes
          // precedence over the alignment check.
          if (al_illegal) begin
            err_bus_d = 1'b1;
            state_d   = DONE;
          end else if (al_misalign) begin
            err_mis_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          if (store_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // A response in the timeout cycle still counts as a success.
        if (mem_rsp_valid) begin
          wb_data_d = al_load;
          wb_we_d   = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_bus_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      f3_q        <= '0;
      alo_q       <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_tag_q    <= '0;
      wb_we_q     <= 1'b0;
      err_mis_q   <= 1'b0;
      err_bus_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wb_data_q   <= wb_data_d;
      wb_tag_q    <= wb_tag_d;
      wb_we_q     <= wb_we_d;
      err_mis_q   <= err_mis_d;
      err_bus_q   <= err_bus_d;
    end
  end

  assign req_ready     = in_idle;
  assign mem_req_valid = (state_q == REQ);
  assign done          = (state_q == DONE);
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign wb_we         = wb_we_q;
  assign wb_data       = wb_data_q;
  assign wb_tag        = wb_tag_q;
  assign err_misalign  = err_mis_q;
  assign err_bus       = err_bus_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rv_lsu.sv
module tb_rv_lsu;
  import rv_pkg::*;

  localparam int TAG_W       = 5;
  localparam int RSP_TIMEOUT = 8;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [TAG_W-1:0] rd_tag;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic             mem_rsp_valid;
  logic [31:0]      mem_rsp_rdata;
  logic             done;
  logic             wb_we;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             err_misalign;
  logic             err_bus;
  lsu_state_t       dbg_state;

  always #5 clk = ~clk;

  rv_lsu #(.TAG_W(TAG_W), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct3(funct3), .addr(addr), .wdata(wdata), .rd_tag(rd_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .done(done), .wb_we(wb_we), .wb_data(wb_data), .wb_tag(wb_tag),
    .err_misalign(err_misalign), .err_bus(err_bus), .dbg_state(dbg_state)
  );

  // ---------------- vector table / scoreboard ----------------
  typedef struct {
    string       name;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  tag;
    int          stall;   // cycles of mem_req_ready=0 in REQ
    int          rsp;     // response this many cycles after handshake; 0 = never
    bit          stale;   // drive junk mem_rsp_valid while in REQ
    bit          bus;     // a bus request is expected
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] data;
    bit          wbwe;
    bit          mis;
    bit          berr;
    int          lat;     // cycles from accept cycle to done cycle
  } vec_t;

  vec_t        tbl[$];
  logic [39:0] exp_q[$];   // {wb_we, err_misalign, err_bus, wb_tag, wb_data}
  logic [68:0] bus_q[$];   // {mem_we, mem_be, mem_addr, mem_wdata}
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic vec_t mk(string name, bit st, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              logic [4:0] tag, int stall, int rsp, bit stale, bit bus,
                              logic [3:0] be, logic [31:0] mwd, logic [31:0] data,
                              bit wbwe, bit mis, bit berr, int lat);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.tag = tag; v.stall = stall; v.rsp = rsp; v.stale = stale; v.bus = bus;
    v.be = be; v.mwdata = mwd; v.data = data; v.wbwe = wbwe; v.mis = mis;
    v.berr = berr; v.lat = lat;
    return v;
  endfunction

  // Reference for random loads, written from the lane/extension rules.
  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] a, logic [31:0] d);
    logic [31:0] s;
    s = d >> {a, 3'b000};
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_BU:   return {24'b0, s[7:0]};
      F3_HU:   return {16'b0, s[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(logic [2:0] f3, logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd(logic [2:0] f3, logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    int          hs_cyc;
    int          done_cyc;
    bit          saw_req;
    bit          stable;
    logic [68:0] snap;
    logic [39:0] rexp;
    logic [39:0] ract;
    hs_cyc = 0; done_cyc = 0; saw_req = 0; stable = 1; snap = '0;

    check({v.name, "/idle"}, req_ready, 1);
    req_valid = 1'b1;
    opcode    = v.st ? OPC_STORE : OPC_LOAD;
    funct3    = v.f3;
    addr      = v.addr;
    wdata     = v.wdata;
    rd_tag    = v.tag;
    exp_q.push_back({v.wbwe, v.mis, v.berr, v.tag, v.data});
    if (v.bus) bus_q.push_back({v.st, v.be, v.addr[31:2], 2'b00, v.mwdata});
    @(posedge clk); #1;
    req_valid = 1'b0;

    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mem_req_valid) begin
        if (!saw_req) begin
          saw_req = 1;
          snap    = {mem_we, mem_be, mem_addr, mem_wdata};
        end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== snap) begin
          stable = 0;
        end
      end
      mem_req_ready = (cyc > v.stall);
      if (mem_req_valid && mem_req_ready && hs_cyc == 0) hs_cyc = cyc;
      if (hs_cyc != 0 && v.rsp != 0 && cyc == hs_cyc + v.rsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = v.rdata;
      end else if (v.stale && mem_req_valid) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_BAD0;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;

    check({v.name, "/done_seen"}, done_cyc != 0, 1);
    if (done_cyc != 0) begin
      rexp = exp_q.pop_front();
      ract = {wb_we, err_misalign, err_bus, wb_tag, wb_data};
      // wb_data carries no meaning unless the load writes back.
      if (!rexp[39]) begin
        rexp[31:0] = '0;
        ract[31:0] = '0;
      end
      check({v.name, "/result"}, ract, rexp);
      check({v.name, "/latency"}, done_cyc, v.lat);
    end
    if (v.bus) begin
      check({v.name, "/bus_req"}, snap, bus_q.pop_front());
      check({v.name, "/bus_stable"}, stable, 1);
    end else begin
      check({v.name, "/no_bus_req"}, saw_req, 0);
    end
    @(posedge clk); #1;
    check({v.name, "/done_pulse"}, {done, req_ready}, 2'b01);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0]  f3s [5];
    logic [2:0]  rf3;
    logic [1:0]  lane;
    logic [31:0] ra, rw, rd;
    int          rs, rr;
    bit          seen;

    f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    //         name          st f3     addr          wdata         rdata        tag stl rsp stale bus be       mwdata        data          we mis be lat
    tbl.push_back(mk("sw",        1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 0, 2));
    tbl.push_back(mk("sb",        1, F3_B,  32'h103, 32'h000000A5, 32'h0,        2, 0, 0, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 0, 0, 2));
    tbl.push_back(mk("sh",        1, F3_H,  32'h102, 32'h1234BEEF, 32'h0,        3, 0, 0, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 0, 2));
    tbl.push_back(mk("sb_stall",  1, F3_B,  32'h001, 32'h0000003C, 32'h0,        4, 3, 0, 0, 1, 4'b0010, 32'h3C3C3C3C, 32'h0,        0, 0, 0, 5));
    tbl.push_back(mk("lb",        0, F3_B,  32'h202, 32'h0,        32'h12F03456, 5, 0, 2, 0, 1, 4'b0100, 32'h0,        32'hFFFFFFF0, 1, 0, 0, 4));
    tbl.push_back(mk("lbu",       0, F3_BU, 32'h202, 32'h0,        32'h12F03456, 6, 0, 2, 0, 1, 4'b0100, 32'h0,        32'h000000F0, 1, 0, 0, 4));
    tbl.push_back(mk("lhu",       0, F3_HU, 32'h200, 32'h0,        32'h12F03456, 7, 0, 2, 0, 1, 4'b0011, 32'h0,        32'h00003456, 1, 0, 0, 4));
    tbl.push_back(mk("lh",        0, F3_H,  32'h202, 32'h0,        32'h80017777, 8, 0, 1, 0, 1, 4'b1100, 32'h0,        32'hFFFF8001, 1, 0, 0, 3));
    tbl.push_back(mk("lw",        0, F3_W,  32'h204, 32'h0,        32'hCAFEF00D, 9, 0, 3, 0, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 1, 0, 0, 5));
    tbl.push_back(mk("lb_top",    0, F3_B,  32'h3FF, 32'h0,        32'h7F000000, 10, 0, 2, 0, 1, 4'b1000, 32'h0,       32'h0000007F, 1, 0, 0, 4));
    tbl.push_back(mk("lw_mis",    0, F3_W,  32'h101, 32'h0,        32'h0,        11, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 1, 0, 1));
    tbl.push_back(mk("lh_mis",    0, F3_H,  32'h103, 32'h0,        32'h0,        12, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 1, 0, 1));
    tbl.push_back(mk("sw_mis",    1, F3_W,  32'h102, 32'h11111111, 32'h0,        13, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 1, 0, 1));
    tbl.push_back(mk("sh_mis",    1, F3_H,  32'h101, 32'h22222222, 32'h0,        14, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 1, 0, 1));
    tbl.push_back(mk("ld_f3_011", 0, 3'b011, 32'h100, 32'h0,       32'h0,        15, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 1, 1));
    tbl.push_back(mk("ld_f3_110", 0, 3'b110, 32'h100, 32'h0,       32'h0,        16, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 1, 1));
    tbl.push_back(mk("st_f3_100", 1, 3'b100, 32'h100, 32'h0,       32'h0,        17, 0, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 1, 1));
    // Handshake in cycle 6, eight WAIT cycles (counter 0..7), done in cycle 15.
    tbl.push_back(mk("lw_timeout", 0, F3_W, 32'h300, 32'h0,        32'h0,        20, 5, 0, 1, 1, 4'b1111, 32'h0,       32'h0,        0, 0, 1, 15));
    // Response lands in the last WAIT cycle (counter == RSP_TIMEOUT-1): it wins.
    tbl.push_back(mk("lw_edge",   0, F3_W,  32'h400, 32'h0,        32'h11223344, 21, 0, 8, 0, 1, 4'b1111, 32'h0,      32'h11223344, 1, 0, 0, 10));

    // Clock/reset
    rst = 1'b1; req_valid = 1'b0; opcode = '0; funct3 = '0; addr = '0; wdata = '0;
    rd_tag = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {req_ready, mem_req_valid, done, wb_we, err_misalign, err_bus, mem_we}, 7'b1000000);
    check("reset_bus", {mem_addr, mem_be, mem_wdata}, 0);
    check("reset_wb", {wb_data, wb_tag}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Random aligned loads with random bus timing.
    for (int i = 0; i < 12; i++) begin
      rf3  = f3s[$urandom_range(0, 4)];
      case (rf3[1:0])
        2'b00:   lane = 2'($urandom_range(0, 3));
        2'b01:   lane = {1'($urandom_range(0, 1)), 1'b0};
        default: lane = 2'b00;
      endcase
      ra = {20'h0, 10'($urandom_range(0, 1023)), lane};
      rw = $urandom;
      rd = $urandom;
      rs = $urandom_range(0, 3);
      rr = $urandom_range(1, RSP_TIMEOUT);
      run_vec(mk("rand_ld", 0, rf3, ra, rw, rd, 5'(i), rs, rr, 0, 1,
                 ref_be(rf3, lane), ref_wd(rf3, rw), ref_load(rf3, lane, rd),
                 1, 0, 0, rs + rr + 2));
    end

    // Reset while waiting for a read response; a late response must be dropped.
    req_valid = 1'b1; opcode = OPC_LOAD; funct3 = F3_W; addr = 32'h500; rd_tag = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("rst_wait/in_wait", dbg_state, WAIT);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait/after", {req_ready, mem_req_valid, done}, 3'b100);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFFFFFF;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) seen = 1;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
    end
    check("rst_wait/no_done", seen, 0);

    // Reset while a store request is stalled on the bus.
    req_valid = 1'b1; opcode = OPC_STORE; funct3 = F3_W; addr = 32'h600; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_req/in_req", mem_req_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_req_ready = 1'b1;
    check("rst_req/dropped", {mem_req_valid, req_ready}, 2'b01);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    check("rst_req/no_done", seen, 0);

    // Normal operation resumes after the aborted accesses.
    run_vec(tbl[4]);

    check("scoreboard_empty", {32'(exp_q.size()), 32'(bus_q.size())}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
